seq_detect_ctrl: RTL

Controller and report arbiter for the dual 4-bit serial pattern detector. It arms the detector for a programmable window of valid input bits and counts hits on both detector outputs. Hits are queued per channel and reported on one shared event port, using a valid/ready handshake with round-robin arbitration. It sits between the detector's `detected_*` pulses and the downstream event consumer.

---
 rtl/seq_detect_pkg.sv | 15 +
 rtl/rr_evt_arb.sv | 65 ++++++
 rtl/seq_detect_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern detector controller.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic       CH_A     = 1'b0;
  localparam logic       CH_B     = 1'b1;
  localparam logic [1:0] PEND_MAX = 2'd3;

endpackage

// File: rtl/rr_evt_arb.sv
// Per-channel pending hit counters feeding one registered valid/ready event slot,
// with round-robin choice between channels.
module rr_evt_arb
  import seq_detect_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic hit_a,
  input  logic hit_b,
  input  logic evt_ready,
  output logic evt_valid,
  output logic evt_id,
  output logic all_empty,
  output logic drop
);

  // Pending counts include the event currently in the slot; they drop on accept.
  logic [1:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic       slot_v_q, slot_v_d, slot_id_q, slot_id_d, ptr_q, ptr_d;
  logic       acc_a, acc_b, avail_a, avail_b, drop_a, drop_b;

  always_comb begin
    acc_a     = slot_v_q & evt_ready & (slot_id_q == CH_A);
    acc_b     = slot_v_q & evt_ready & (slot_id_q == CH_B);
    avail_a   = pend_a_q > {1'b0, acc_a};
    avail_b   = pend_b_q > {1'b0, acc_b};
    drop_a    = hit_a & (pend_a_q == PEND_MAX);
    drop_b    = hit_b & (pend_b_q == PEND_MAX);
    pend_a_d  = pend_a_q + {1'b0, hit_a & ~drop_a} - {1'b0, acc_a};
    pend_b_d  = pend_b_q + {1'b0, hit_b & ~drop_b} - {1'b0, acc_b};
    slot_v_d  = slot_v_q;
    slot_id_d = slot_id_q;
    ptr_d     = ptr_q;
    if (!slot_v_q || evt_ready) begin
      slot_v_d = avail_a | avail_b;
      if (avail_a && avail_b) slot_id_d = ptr_q;
      else if (avail_a)       slot_id_d = CH_A;
      else if (avail_b)       slot_id_d = CH_B;
      if (avail_a || avail_b) ptr_d = ~slot_id_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      pend_a_q  <= 2'd0;
      pend_b_q  <= 2'd0;
      slot_v_q  <= 1'b0;
      slot_id_q <= CH_A;
      ptr_q     <= CH_A;
    end else begin
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
      slot_v_q  <= slot_v_d;
      slot_id_q <= slot_id_d;
      ptr_q     <= ptr_d;
    end
  end

  assign evt_valid = slot_v_q;
  assign evt_id    = slot_id_q;
  assign all_empty = (pend_a_q == 2'd0) && (pend_b_q == 2'd0);
  assign drop      = drop_a | drop_b;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Window sequencer and hit counters for the dual pattern detector; hits are
// reported through rr_evt_arb on a shared valid/ready event port.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] window_len,
  input  logic             in_valid,
  input  logic             det_a,
  input  logic             det_b,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic             evt_id,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hits_a,
  output logic [CNT_W-1:0] hits_b,
  output logic             overflow
);

  // state | meaning
  // IDLE  | waiting for start
  // ARMED | counting hits over the window
  // DRAIN | window over, flushing pending events
  // DONE  | one-cycle completion pulse
  state_e           state_q, state_d;
  logic [WIN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] hits_a_q, hits_a_d, hits_b_q, hits_b_d;
  logic             ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;
  logic             clr, hit_a, hit_b, sat_a, sat_b, all_empty, drop;

  assign hit_a = (state_q == ARMED) & in_valid & det_a;
  assign hit_b = (state_q == ARMED) & in_valid & det_b;

  rr_evt_arb u_arb (
    .clock     (clock),
    .reset     (reset),
    .clr       (clr),
    .hit_a     (hit_a),
    .hit_b     (hit_b),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .all_empty (all_empty),
    .drop      (drop)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    hits_a_d = hits_a_q;
    hits_b_d = hits_b_q;
    ovf_d    = ovf_q;
    clr      = 1'b0;
    sat_a    = hit_a & (hits_a_q == {CNT_W{1'b1}});
    sat_b    = hit_b & (hits_b_q == {CNT_W{1'b1}});
    if (hit_a && !sat_a) hits_a_d = hits_a_q + CNT_W'(1);
    if (hit_b && !sat_b) hits_b_d = hits_b_q + CNT_W'(1);
    if (drop || sat_a || sat_b) ovf_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ARMED;
          rem_d    = window_len;
          hits_a_d = '0;
          hits_b_d = '0;
          ovf_d    = 1'b0;
          clr      = 1'b1;
        end
      end
      ARMED: begin
        // remaining == 0 at entry means unbounded: only stop ends the window
        if (in_valid && rem_q != '0) begin
          rem_d = rem_q - WIN_W'(1);
          if (rem_q == WIN_W'(1)) state_d = DRAIN;
        end
        if (stop) state_d = DRAIN;
      end
      DRAIN:   if (all_empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ARMED) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      hits_a_q <= '0;
      hits_b_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      hits_a_q <= hits_a_d;
      hits_b_q <= hits_b_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hits_a   = hits_a_q;
  assign hits_b   = hits_b_q;
  assign overflow = ovf_q;

endmodule
